// File: rtl/if_ex_buffer.sv
// IF/EX pipeline register with hold, bubble and squash control, a hold watchdog,
// and optional performance counters enabled by the IF_EX_PERF_CNT_EN macro.
module if_ex_buffer #(
   parameter logic [31:0] NOP_INSTR  = 32'h00000013,
   parameter int          WDOG_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   input  logic [31:0] ir_if,
   input  logic        wren_if,
   input  logic        stall_if,
   input  logic        stall_ex,
   input  logic        flush,
   output logic [31:0] pc_ex,
   output logic [31:0] ir_ex,
   output logic        buff_wren,
   output logic        valid_ex,
   output logic [1:0]  state,
   output logic        stall_err,
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      BUBBLE = 2'd2,
      SQUASH = 2'd3
   } state_t;

   localparam int HW = $clog2(WDOG_LIMIT + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(WDOG_LIMIT);

   state_t        state_q;
   logic [31:0]   pc_ex_q;
   logic [31:0]   ir_ex_q;
   logic          buff_wren_q;
   logic          valid_ex_q;
   logic          stall_err_q;
   logic [HW-1:0] hold_run_q;
   logic [HW-1:0] hold_run_d;
   logic          hold_edge;

   // A flush overrides both stalls, so a hold only happens when flush is low.
   assign hold_edge = ~flush & stall_if & stall_ex;

   always_comb begin
      hold_run_d = '0;
      if (hold_edge) begin
         hold_run_d = (hold_run_q == HOLD_MAX) ? hold_run_q : hold_run_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_ex_q     <= '0;
         ir_ex_q     <= NOP_INSTR;
         buff_wren_q <= 1'b0;
         valid_ex_q  <= 1'b0;
         stall_err_q <= 1'b0;
         hold_run_q  <= '0;
      end else begin
         hold_run_q <= hold_run_d;
         if (hold_run_d == HOLD_MAX) begin
            stall_err_q <= 1'b1;
         end
         if (flush) begin
            state_q     <= SQUASH;
            pc_ex_q     <= pc_if;
            ir_ex_q     <= NOP_INSTR;
            buff_wren_q <= 1'b0;
            valid_ex_q  <= 1'b0;
         end else if (stall_if && stall_ex) begin
            state_q <= HOLD;
         end else if (stall_if) begin
            state_q     <= BUBBLE;
            ir_ex_q     <= NOP_INSTR;
            buff_wren_q <= 1'b0;
            valid_ex_q  <= 1'b0;
         end else if (state_q == SQUASH) begin
            // Second squash cycle drops the synchronously fetched branch target slot.
            state_q     <= RUN;
            pc_ex_q     <= pc_if;
            ir_ex_q     <= NOP_INSTR;
            buff_wren_q <= 1'b0;
            valid_ex_q  <= 1'b0;
         end else begin
            state_q     <= RUN;
            pc_ex_q     <= pc_if;
            ir_ex_q     <= ir_if;
            buff_wren_q <= wren_if;
            valid_ex_q  <= 1'b1;
         end
      end
   end

   assign pc_ex     = pc_ex_q;
   assign ir_ex     = ir_ex_q;
   assign buff_wren = buff_wren_q;
   assign valid_ex  = valid_ex_q;
   assign state     = state_q;
   assign stall_err = stall_err_q;

`ifdef IF_EX_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] bubble_cnt_q;
   logic [31:0] flush_cnt_q;
   logic        bubble_edge;

   assign bubble_edge = ~flush & stall_if & ~stall_ex;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (hold_edge && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (bubble_edge && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
         if (flush && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
   assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_if_ex_buffer.sv
// Self-checking bench for if_ex_buffer: directed scenarios plus random traffic
// against a behavioural model of the pipeline-register rules.
module tb_if_ex_buffer;

   localparam logic [31:0] NOP  = 32'h00000013;
   localparam int          WDOG = 16;

   logic        clk = 1'b0;
   logic        rst, wren_if, stall_if, stall_ex, flush;
   logic [31:0] pc_if, ir_if;
   logic [31:0] pc_ex, ir_ex, stall_cnt, bubble_cnt, flush_cnt;
   logic        buff_wren, valid_ex, stall_err;
   logic [1:0]  state;

   int vecs = 0;
   int miscmp = 0;

   // Behavioural model of the EX slot
   logic [31:0] m_pc, m_ir, m_sc, m_bc, m_fc;
   logic        m_wren, m_valid, m_err;
   logic [1:0]  m_state;
   int          m_holds;

   if_ex_buffer #(.NOP_INSTR(NOP), .WDOG_LIMIT(WDOG)) dut (
      .clk(clk), .rst(rst), .pc_if(pc_if), .ir_if(ir_if), .wren_if(wren_if),
      .stall_if(stall_if), .stall_ex(stall_ex), .flush(flush),
      .pc_ex(pc_ex), .ir_ex(ir_ex), .buff_wren(buff_wren), .valid_ex(valid_ex),
      .state(state), .stall_err(stall_err), .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [164:0] dut_vec();
      return {pc_ex, ir_ex, buff_wren, valid_ex, state, stall_err, stall_cnt, bubble_cnt, flush_cnt};
   endfunction

   function automatic logic [164:0] exp_vec();
      return {m_pc, m_ir, m_wren, m_valid, m_state, m_err, m_sc, m_bc, m_fc};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
   endfunction

   // Applies the priority rules to the inputs present at this clock edge.
   task automatic model_step();
      bit hold_now;
      hold_now = 0;
      if (rst) begin
         m_pc = 0; m_ir = NOP; m_wren = 0; m_valid = 0; m_state = 2'd0;
         m_err = 0; m_holds = 0; m_sc = 0; m_bc = 0; m_fc = 0;
         return;
      end
      if (flush) begin
         m_pc = pc_if; m_ir = NOP; m_wren = 0; m_valid = 0; m_state = 2'd3;
`ifdef IF_EX_PERF_CNT_EN
         m_fc = sat_inc(m_fc);
`endif
      end else if (stall_if && stall_ex) begin
         m_state = 2'd1;
         hold_now = 1;
`ifdef IF_EX_PERF_CNT_EN
         m_sc = sat_inc(m_sc);
`endif
      end else if (stall_if) begin
         m_ir = NOP; m_wren = 0; m_valid = 0; m_state = 2'd2;
`ifdef IF_EX_PERF_CNT_EN
         m_bc = sat_inc(m_bc);
`endif
      end else if (m_state == 2'd3) begin
         m_pc = pc_if; m_ir = NOP; m_wren = 0; m_valid = 0; m_state = 2'd0;
      end else begin
         m_pc = pc_if; m_ir = ir_if; m_wren = wren_if; m_valid = 1; m_state = 2'd0;
      end
      m_holds = hold_now ? ((m_holds < WDOG) ? m_holds + 1 : WDOG) : 0;
      if (m_holds == WDOG) m_err = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic r, input logic f, input logic si, input logic se,
                        input logic [31:0] ir, input logic w);
      rst = r; flush = f; stall_if = si; stall_ex = se; ir_if = ir; wren_if = w;
      pc_if = $urandom;
   endtask

   task automatic test_reset();
      drive(1, 1, 1, 1, $urandom, 1);
      tick();
      tick();
      drive(0, 0, 0, 0, $urandom, 0);
      vecs++;
      if (dut_vec() !== exp_vec()) begin
         miscmp++;
         $display("FAIL reset_state got=%h want=%h", dut_vec(), exp_vec());
      end
      vecs++;
      if ({pc_ex, ir_ex, buff_wren, valid_ex, state, stall_err} !== {32'd0, NOP, 1'b0, 1'b0, 2'd0, 1'b0}) begin
         miscmp++;
         $display("FAIL reset_values got pc=%h ir=%h w=%b v=%b st=%0d err=%b want pc=0 ir=%h w=0 v=0 st=0 err=0",
                  pc_ex, ir_ex, buff_wren, valid_ex, state, stall_err, NOP);
      end
   endtask

   task automatic test_load();
      drive(0, 0, 0, 0, 32'h00500093, 1);
      tick();
      vecs++;
      if ({ir_ex, buff_wren, valid_ex, state, pc_ex} !== {32'h00500093, 1'b1, 1'b1, 2'd0, pc_if}) begin
         miscmp++;
         $display("FAIL load got ir=%h w=%b v=%b st=%0d pc=%h want ir=00500093 w=1 v=1 st=0 pc=%h",
                  ir_ex, buff_wren, valid_ex, state, pc_ex, pc_if);
      end
      vecs++;
      if (dut_vec() !== exp_vec()) begin
         miscmp++;
         $display("FAIL load_model got=%h want=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_flush();
      logic [31:0] want_ir [3];
      logic [1:0]  want_st [3];
      want_ir[0] = NOP; want_ir[1] = NOP;  want_ir[2] = 32'h00A00113;
      want_st[0] = 2'd3; want_st[1] = 2'd0; want_st[2] = 2'd0;
      drive(0, 1, 0, 0, $urandom, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++;
         if ({ir_ex, state} !== {want_ir[i], want_st[i]} || dut_vec() !== exp_vec()) begin
            miscmp++;
            $display("FAIL flush_edge%0d got ir=%h st=%0d want ir=%h st=%0d", i + 1, ir_ex, state, want_ir[i], want_st[i]);
         end
         drive(0, 0, 0, 0, 32'h00A00113, 1);
      end
      // A flush inside the squash window restarts it
      drive(0, 1, 0, 0, $urandom, 1);
      tick();
      drive(0, 1, 0, 0, $urandom, 1);
      tick();
      vecs++;
      if ({state, valid_ex} !== {2'd3, 1'b0}) begin
         miscmp++;
         $display("FAIL flush_restart got st=%0d v=%b want st=3 v=0", state, valid_ex);
      end
      drive(0, 0, 0, 0, 32'h12345678, 1);
      tick();
      vecs++;
      if ({state, ir_ex, valid_ex, buff_wren} !== {2'd0, NOP, 1'b0, 1'b0} || dut_vec() !== exp_vec()) begin
         miscmp++;
         $display("FAIL flush_restart_discard got st=%0d ir=%h v=%b want st=0 ir=%h v=0", state, ir_ex, valid_ex, NOP);
      end
   endtask

   task automatic test_hold();
      logic [31:0] held_pc;
      drive(1, 0, 0, 0, $urandom, 0);
      tick();
      drive(0, 0, 0, 0, 32'h0000A183, 1);
      tick();
      held_pc = pc_ex;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 1, $urandom, 0);
         tick();
         vecs++;
         if ({ir_ex, pc_ex, buff_wren, valid_ex, state} !== {32'h0000A183, held_pc, 1'b1, 1'b1, 2'd1}) begin
            miscmp++;
            $display("FAIL hold_edge%0d got ir=%h pc=%h st=%0d want ir=0000a183 pc=%h st=1", i + 1, ir_ex, pc_ex, state, held_pc);
         end
      end
      vecs++;
`ifdef IF_EX_PERF_CNT_EN
      if (stall_cnt !== 32'd3) begin
         miscmp++;
         $display("FAIL hold_stall_cnt got=%0d want=3", stall_cnt);
      end
`else
      if (stall_cnt !== 32'd0) begin
         miscmp++;
         $display("FAIL hold_stall_cnt got=%0d want=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_bubble();
      logic [31:0] held_pc;
      drive(0, 0, 0, 0, 32'h00C00193, 1);
      tick();
      held_pc = pc_ex;
      drive(0, 0, 1, 0, $urandom, 1);
      tick();
      vecs++;
      if ({ir_ex, buff_wren, valid_ex, pc_ex, state} !== {NOP, 1'b0, 1'b0, held_pc, 2'd2} || dut_vec() !== exp_vec()) begin
         miscmp++;
         $display("FAIL bubble got ir=%h w=%b pc=%h st=%0d bc=%0d want ir=%h w=0 pc=%h st=2 bc=%0d",
                  ir_ex, buff_wren, pc_ex, state, bubble_cnt, NOP, held_pc, m_bc);
      end
      drive(0, 1, 1, 1, $urandom, 1);
      tick();
      vecs++;
      if ({state, pc_ex, ir_ex} !== {2'd3, pc_if, NOP} || dut_vec() !== exp_vec()) begin
         miscmp++;
         $display("FAIL flush_over_stall got st=%0d pc=%h want st=3 pc=%h", state, pc_ex, pc_if);
      end
   endtask

   task automatic test_watchdog();
      drive(1, 0, 0, 0, $urandom, 0);
      tick();
      drive(0, 0, 0, 0, $urandom, 1);
      tick();
      for (int i = 1; i <= WDOG; i++) begin
         drive(0, 0, 1, 1, $urandom, 0);
         tick();
         if (i >= WDOG - 1) begin
            vecs++;
            if (stall_err !== (i == WDOG) || dut_vec() !== exp_vec()) begin
               miscmp++;
               $display("FAIL wdog_edge%0d got err=%b want err=%b", i, stall_err, i == WDOG);
            end
         end
      end
      drive(0, 0, 0, 0, $urandom, 1);
      tick();
      tick();
      vecs++;
      if ({stall_err, state, valid_ex} !== {1'b1, 2'd0, 1'b1}) begin
         miscmp++;
         $display("FAIL wdog_sticky got err=%b st=%0d want err=1 st=0", stall_err, state);
      end
      drive(0, 0, 1, 1, $urandom, 0);
      tick();
      tick();
      drive(1, 0, 1, 1, $urandom, 0);
      tick();
      vecs++;
      if (dut_vec() !== {32'd0, NOP, 1'b0, 1'b0, 2'd0, 1'b0, 96'd0}) begin
         miscmp++;
         $display("FAIL rst_mid_hold got=%h want=%h", dut_vec(), {32'd0, NOP, 1'b0, 1'b0, 2'd0, 1'b0, 96'd0});
      end
      drive(0, 0, 0, 0, 32'h00100073, 1);
      tick();
      vecs++;
      if ({state, ir_ex, valid_ex} !== {2'd0, 32'h00100073, 1'b1}) begin
         miscmp++;
         $display("FAIL post_rst_load got st=%0d ir=%h want st=0 ir=00100073", state, ir_ex);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
         // Occasional long hold bursts push the watchdog
         if (n % 150 > 120 && n % 150 < 140) begin
            rst = 0; flush = 0; stall_if = 1; stall_ex = 1;
         end
         tick();
         vecs++;
         if (dut_vec() !== exp_vec()) begin
            miscmp++;
            $display("FAIL random_%0d got=%h want=%h", n, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      m_pc = 0; m_ir = NOP; m_wren = 0; m_valid = 0; m_state = 0;
      m_err = 0; m_holds = 0; m_sc = 0; m_bc = 0; m_fc = 0;
      drive(1, 0, 0, 0, 0, 0);
      #1;
      test_reset();
      test_load();
      test_flush();
      test_hold();
      test_bubble();
      test_watchdog();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
